// File: rtl/fifo_serial_drain.sv
// fifo_serial_drain: pops bytes from the 16x8 FIFO read port and shifts each out as a start/8-data/stop serial frame.
// Defining FIFO_DRAIN_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module fifo_serial_drain #(
   parameter int DIV = 16,
   parameter int CW  = 16
) (
   input  logic       ck,
   input  logic       rst,
   input  logic       Fempty,
   input  logic [7:0] Fdout,
   output logic       Ren,
   output logic       TxD,
   output logic       Busy,
   output logic       Tdone
);

`ifdef FIFO_DRAIN_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic          r_ren;
   logic          r_txd;
   logic          r_busy;
   logic          r_tdone;
`ifdef FIFO_DRAIN_PARITY_EN
   logic          r_par;
`endif

   logic w_bit_end;
   logic w_tdone_next;

   assign w_bit_end    = (r_cnt == '0);
   // Tdone is registered, so it is raised one cycle ahead: when the stop bit has one cycle left.
   assign w_tdone_next = (r_state == S_STOP) && (r_cnt == CW'(1));

   always_ff @(posedge ck) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_ren   <= 1'b1;
         r_txd   <= 1'b1;
         r_busy  <= 1'b0;
         r_tdone <= 1'b0;
`ifdef FIFO_DRAIN_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         r_ren   <= 1'b1;
         r_tdone <= w_tdone_next;
         case (r_state)
            S_IDLE: begin
               if (!Fempty) begin
                  r_shift <= Fdout;
                  r_ren   <= 1'b0;
                  r_txd   <= 1'b0;
                  r_cnt   <= RELOAD;
                  r_bit   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_START;
`ifdef FIFO_DRAIN_PARITY_EN
                  r_par   <= ^Fdout;
`endif
               end else begin
                  r_txd <= 1'b1;
               end
            end
            S_START: begin
               if (w_bit_end) begin
                  r_cnt   <= RELOAD;
                  r_bit   <= '0;
                  r_txd   <= r_shift[0];
                  r_state <= S_DATA;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  r_cnt   <= RELOAD;
                  r_shift <= {1'b0, r_shift[7:1]};
                  if (r_bit == 3'd7) begin
`ifdef FIFO_DRAIN_PARITY_EN
                     r_txd   <= r_par;
                     r_state <= S_PARITY;
`else
                     r_txd   <= 1'b1;
                     r_state <= S_STOP;
`endif
                  end else begin
                     r_txd <= r_shift[1];
                     r_bit <= r_bit + 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
`ifdef FIFO_DRAIN_PARITY_EN
            S_PARITY: begin
               if (w_bit_end) begin
                  r_cnt   <= RELOAD;
                  r_txd   <= 1'b1;
                  r_state <= S_STOP;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
`endif
            S_STOP: begin
               if (w_bit_end) begin
                  r_cnt   <= RELOAD;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: begin
               r_txd   <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign Ren   = r_ren;
   assign TxD   = r_txd;
   assign Busy  = r_busy;
   assign Tdone = r_tdone;

endmodule

// File: tb/tb_fifo_serial_drain.sv
// Bench for fifo_serial_drain: two instances (DIV=4 and DIV=2) fed from queue-based FIFO models,
// every output compared cycle by cycle against frames built from the serial framing rules.
module tb_fifo_serial_drain;

   localparam int DA = 4;
   localparam int DB = 2;
`ifdef FIFO_DRAIN_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic       ck  = 1'b0;
   logic       rst = 1'b1;
   logic       fe0 = 1'b1;
   logic       fe1 = 1'b1;
   logic [7:0] fd0 = 8'h00;
   logic [7:0] fd1 = 8'h00;
   logic       ren0, txd0, busy0, td0;
   logic       ren1, txd1, busy1, td1;
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic [7:0] bq[$];
   int         pops0  = 0;
   int         pops1  = 0;
   int         errors = 0;
   int         checks = 0;
   int         p;

   always #5 ck = ~ck;

   fifo_serial_drain #(.DIV(DA), .CW(16)) u_a (
      .ck(ck), .rst(rst), .Fempty(fe0), .Fdout(fd0),
      .Ren(ren0), .TxD(txd0), .Busy(busy0), .Tdone(td0)
   );

   fifo_serial_drain #(.DIV(DB), .CW(8)) u_b (
      .ck(ck), .rst(rst), .Fempty(fe1), .Fdout(fd1),
      .Ren(ren1), .TxD(txd1), .Busy(busy1), .Tdone(td1)
   );

   // One clock: the FIFO models pop on a low Ren seen at the edge and present registered flags/data.
   task automatic cycle();
      @(posedge ck);
      if (ren0 == 1'b0) begin
         pops0++;
         if (q0.size() > 0) void'(q0.pop_front());
      end
      if (ren1 == 1'b0) begin
         pops1++;
         if (q1.size() > 0) void'(q1.pop_front());
      end
      fe0 <= (q0.size() == 0);
      fd0 <= (q0.size() > 0) ? q0[0] : 8'h00;
      fe1 <= (q1.size() == 0);
      fd1 <= (q1.size() > 0) ? q1[0] : 8'h00;
      @(negedge ck);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Packed as {Ren, TxD, Busy, Tdone}; idle is 4'b1100.
   function automatic logic [3:0] outs(input int s);
      return (s == 0) ? {ren0, txd0, busy0, td0} : {ren1, txd1, busy1, td1};
   endfunction

   function automatic int pops(input int s);
      return (s == 0) ? pops0 : pops1;
   endfunction

   function automatic int qsize(input int s);
      return (s == 0) ? q0.size() : q1.size();
   endfunction

   function automatic logic frame_bit(input logic [7:0] b, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
      if (idx == 9 && NB == 11) return ^b;
      return 1'b1;
   endfunction

   task automatic frame(input int s, input logic [7:0] b, input int ncyc, input string nm);
      int d;
      d = (s == 0) ? DA : DB;
      for (int j = 0; j < ncyc; j++) begin
         cycle();
         chk($sformatf("%s c%0d", nm, j), outs(s),
             {(j == 0) ? 1'b0 : 1'b1, frame_bit(b, j / d), 1'b1, (j == NB*d-1)});
      end
   endtask

   task automatic idle_chk(input int s, input int n, input string nm);
      for (int j = 0; j < n; j++) begin
         cycle();
         chk($sformatf("%s idle%0d", nm, j), outs(s), 4'b1100);
      end
   endtask

   task automatic run_frames(input int s, input logic [7:0] b[$], input string nm);
      int d;
      int p0;
      d  = (s == 0) ? DA : DB;
      p0 = pops(s);
      foreach (b[k]) begin
         if (s == 0) q0.push_back(b[k]);
         else        q1.push_back(b[k]);
      end
      cycle();
      chk({nm, " lead"}, outs(s), 4'b1100);
      foreach (b[k]) begin
         frame(s, b[k], NB*d, $sformatf("%s f%0d", nm, k));
         cycle();
         chk($sformatf("%s gap%0d", nm, k), outs(s), 4'b1100);
      end
      chk({nm, " pops"}, pops(s) - p0, b.size());
      chk({nm, " empty"}, qsize(s), 0);
   endtask

   initial begin
      repeat (3) cycle();
      chk("reset a", outs(0), 4'b1100);
      chk("reset b", outs(1), 4'b1100);
      rst = 1'b0;
      idle_chk(0, 20, "empty a");
      idle_chk(1, 4, "empty b");

      bq.delete(); bq.push_back(8'hA5);
      run_frames(0, bq, "A5");

      bq.delete(); bq.push_back(8'h01); bq.push_back(8'hFF); bq.push_back(8'h00);
      run_frames(0, bq, "b2b");

      // Reset during data bit 3: the popped byte is dropped, no new pop while empty.
      p = pops0;
      q0.push_back(8'h3C);
      cycle();
      chk("3C lead", outs(0), 4'b1100);
      frame(0, 8'h3C, DA*4 + 2, "3C");
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("3C after rst", outs(0), 4'b1100);
      idle_chk(0, 20, "3C post");
      chk("3C pops", pops0 - p, 1);

      // Reset while Ren is low: the pop still lands in the FIFO.
      p = pops0;
      q0.push_back(8'h5A);
      cycle();
      chk("5A lead", outs(0), 4'b1100);
      frame(0, 8'h5A, 1, "5A");
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("5A after rst", outs(0), 4'b1100);
      idle_chk(0, 10, "5A post");
      chk("5A pops", pops0 - p, 1);
      chk("5A empty", q0.size(), 0);

      bq.delete(); bq.push_back(8'h07); bq.push_back(8'h03);
      run_frames(0, bq, "par");

      bq.delete();
      repeat (5) bq.push_back(8'($urandom));
      run_frames(0, bq, "rnd a");

      bq.delete();
      repeat (16) bq.push_back(8'($urandom));
      run_frames(1, bq, "full b");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
